// File: rtl/demux1_4_buf_if.sv
// Handshake bundle for demux1_4_buf: one valid/ready input port and four
// valid/ready output lanes, plus the round-robin pointer.
interface demux1_4_buf_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic             auto;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       ptr;

    // master = producer/consumer side, slave = the demultiplexer itself
    modport master (
        output data_in, in_valid, sel, auto, out_ready,
        input  in_ready, out0, out1, out2, out3, out_valid, ptr
    );

    modport slave (
        input  data_in, in_valid, sel, auto, out_ready,
        output in_ready, out0, out1, out2, out3, out_valid, ptr
    );
endinterface

// File: rtl/demux1_4_buf.sv
// Buffered 1-to-4 demultiplexer: each accepted word lands in a one-deep lane
// register chosen by sel or by a round-robin pointer.
module demux1_4_buf #(
    parameter int WIDTH = 4
) (
    input logic            clk,
    input logic            reset,
    demux1_4_buf_if.slave  bus
);
    localparam int LANES = 4;

    logic [WIDTH-1:0] lane_data      [LANES];
    logic [WIDTH-1:0] lane_data_next [LANES];
    logic [LANES-1:0] lane_valid;
    logic [LANES-1:0] lane_valid_next;
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_next;
    logic [1:0]       target;
    logic             accept;

    assign target = bus.auto ? ptr_q : bus.sel;

    // Only the target lane can block the input; a draining lane frees its slot this cycle.
    assign bus.in_ready = !reset && (!lane_valid[target] || bus.out_ready[target]);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default before any condition, so no path leaves one unassigned (no latch).
        lane_data_next  = lane_data;
        lane_valid_next = lane_valid & ~bus.out_ready;
        ptr_next        = ptr_q;
        if (accept) begin
            lane_data_next[target]  = bus.data_in;
            lane_valid_next[target] = 1'b1;
            if (bus.auto) begin
                ptr_next = ptr_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so all registers update together from pre-edge values.
        if (reset) begin
            // NOTE: the lane data registers are reset as well, not just the valid bits, because outputs must read zero after reset.
            for (int i = 0; i < LANES; i++) begin
                lane_data[i] <= '0;
            end
            lane_valid <= '0;
            ptr_q      <= '0;
        end else begin
            lane_data  <= lane_data_next;
            lane_valid <= lane_valid_next;
            ptr_q      <= ptr_next;
        end
    end

    assign bus.out0      = lane_data[0];
    assign bus.out1      = lane_data[1];
    assign bus.out2      = lane_data[2];
    assign bus.out3      = lane_data[3];
    assign bus.out_valid = lane_valid;
    assign bus.ptr       = ptr_q;
endmodule

// File: tb/tb_demux1_4_buf.sv
// Self-checking bench for demux1_4_buf: per-lane scoreboard queues filled when
// words are offered and drained when a lane hands a word to its consumer.
module tb_demux1_4_buf;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [WIDTH-1:0] exp_q [4][$];
    logic [3:0]       pushed_now;
    logic [1:0]       exp_ptr;

    demux1_4_buf_if #(.WIDTH(WIDTH)) bus ();

    demux1_4_buf #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] lane_val(input int i);
        case (i)
            0:       return bus.out0;
            1:       return bus.out1;
            2:       return bus.out2;
            default: return bus.out3;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
        end
        pushed_now = '0;
        exp_ptr    = '0;
    endtask

    // Drive one cycle of stimulus; expected readiness comes from the scoreboard occupancy.
    task automatic send(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] s,
                        input logic a, input logic [3:0] r);
        logic [1:0] t;
        logic       exp_rdy;
        bus.in_valid  = v;
        bus.data_in   = d;
        bus.sel       = s;
        bus.auto      = a;
        bus.out_ready = r;
        #1;
        t       = a ? exp_ptr : s;
        exp_rdy = !reset && (exp_q[t].size() == 0 || r[t]);
        total++;
        if (bus.in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL in_ready: got %b want %b (target=%0d)", bus.in_ready, exp_rdy, t);
        end
        if (v && exp_rdy) begin
            exp_q[t].push_back(d);
            pushed_now[t] = 1'b1;
            if (a) exp_ptr = exp_ptr + 2'd1;
        end
    endtask

    // Compare lanes against the scoreboard at the falling edge, then advance one clock.
    task automatic tick();
        logic expv;
        @(negedge clk);
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                expv = (exp_q[i].size() > int'(pushed_now[i]));
                total++;
                if (bus.out_valid[i] !== expv) begin
                    bad++;
                    $display("FAIL lane%0d_valid: got %b want %b", i, bus.out_valid[i], expv);
                end
                if (expv) begin
                    total++;
                    if (lane_val(i) !== exp_q[i][0]) begin
                        bad++;
                        $display("FAIL lane%0d_data: got %h want %h", i, lane_val(i), exp_q[i][0]);
                    end
                    if (bus.out_ready[i]) void'(exp_q[i].pop_front());
                end
            end
        end
        pushed_now = '0;
        @(posedge clk);
        #1;
        total++;
        if (bus.ptr !== exp_ptr) begin
            bad++;
            $display("FAIL ptr: got %b want %b", bus.ptr, exp_ptr);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.data_in   = 4'hF;
        bus.sel       = 2'd0;
        bus.auto      = 1'b0;
        bus.out_ready = 4'b0000;
        clear_model();
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_in_ready: got %b want 0 (cycle %0d)", bus.in_ready, c);
            end
            @(posedge clk);
        end
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 4'b0000 || bus.ptr !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: out_valid=%b ptr=%b want 0000/00", bus.out_valid, bus.ptr);
        end
        total++;
        if ({bus.out0, bus.out1, bus.out2, bus.out3} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data: got %h%h%h%h want 0000", bus.out0, bus.out1, bus.out2, bus.out3);
        end
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            #1;
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL post_reset_ready: got %b want 1 (sel=%0d)", bus.in_ready, s);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_manual_route();
        send(1'b1, 4'hA, 2'b10, 1'b0, 4'b0000);
        tick();
        total++;
        if (bus.out2 !== 4'hA || bus.out_valid !== 4'b0100) begin
            bad++;
            $display("FAIL manual_route: out2=%h out_valid=%b want a/0100", bus.out2, bus.out_valid);
        end
        send(1'b0, 4'h0, 2'b10, 1'b0, 4'b0000);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_sel2: got %b want 0", bus.in_ready);
        end
        bus.sel = 2'b01;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL free_sel1: got %b want 1", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_drain_reload();
        send(1'b1, 4'h5, 2'b10, 1'b0, 4'b0100);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL drain_reload_ready: got %b want 1", bus.in_ready);
        end
        tick();
        total++;
        if (bus.out2 !== 4'h5 || bus.out_valid !== 4'b0100) begin
            bad++;
            $display("FAIL drain_reload: out2=%h out_valid=%b want 5/0100", bus.out2, bus.out_valid);
        end
    endtask

    task automatic test_round_robin();
        int         rr_lane [5] = '{0, 1, 2, 3, 0};
        logic [1:0] rr_ptr  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 5; k++) begin
            send(1'b1, 4'(k + 1), 2'($urandom_range(0, 3)), 1'b1, 4'b1111);
            tick();
            total++;
            if (bus.ptr !== rr_ptr[k] || bus.out_valid[rr_lane[k]] !== 1'b1 ||
                lane_val(rr_lane[k]) !== 4'(k + 1)) begin
                bad++;
                $display("FAIL round_robin[%0d]: ptr=%b lane%0d=%h valid=%b want ptr=%b data=%h",
                         k, bus.ptr, rr_lane[k], lane_val(rr_lane[k]),
                         bus.out_valid[rr_lane[k]], rr_ptr[k], 4'(k + 1));
            end
        end
    endtask

    task automatic test_rr_stall();
        send(1'b1, 4'h6, 2'b01, 1'b0, 4'b0000);
        tick();
        send(1'b1, 4'h7, 2'b00, 1'b1, 4'b0001);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rr_stall_ready: got %b want 0", bus.in_ready);
        end
        tick();
        total++;
        if (bus.ptr !== 2'b01 || bus.out_valid !== 4'b0010) begin
            bad++;
            $display("FAIL rr_stall: ptr=%b out_valid=%b want 01/0010", bus.ptr, bus.out_valid);
        end
    endtask

    task automatic test_mid_reset();
        send(1'b1, 4'hB, 2'b00, 1'b1, 4'b0010);
        tick();
        send(1'b1, 4'hC, 2'b00, 1'b0, 4'b0000);
        tick();
        send(1'b1, 4'hD, 2'b10, 1'b0, 4'b0000);
        tick();
        send(1'b1, 4'hE, 2'b11, 1'b0, 4'b0000);
        tick();
        total++;
        if (bus.out_valid !== 4'b1111 || bus.ptr !== 2'b10) begin
            bad++;
            $display("FAIL pre_reset_fill: out_valid=%b ptr=%b want 1111/10", bus.out_valid, bus.ptr);
        end
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_ready: got %b want 0", bus.in_ready);
        end
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (bus.out_valid !== 4'b0000 || bus.ptr !== 2'b00 ||
            {bus.out0, bus.out1, bus.out2, bus.out3} !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset: out_valid=%b ptr=%b data=%h%h%h%h want 0000/00/0000",
                     bus.out_valid, bus.ptr, bus.out0, bus.out1, bus.out2, bus.out3);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_manual_route();
        test_drain_reload();
        test_round_robin();
        test_rr_stall();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux1_4_buf.md
# demux1_4_buf

Buffered 1-to-4 demultiplexer: the distribution-side counterpart of the 4:1 data selector in the combinational-circuits lab set. It accepts one WIDTH-bit word per cycle on a valid/ready input port and routes it into one of four output lanes. Each lane has a one-deep holding register and its own valid/ready handshake. The target lane comes from an explicit `sel` input or from an internal round-robin pointer (`auto` mode).

## Interface
Parameters:
- `WIDTH`, default 4: data width of the input word and each output lane.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  input word.
- `in_valid`  in  1  `data_in` is valid this cycle.
- `in_ready`  out  1  block accepts `data_in` this cycle.
- `sel`  in  2  target lane when `auto`=0 (00→lane0 … 11→lane3).
- `auto`  in  1  1 = use the round-robin pointer as the target and ignore `sel`.
- `out0`, `out1`, `out2`, `out3`  out  WIDTH each  lane holding registers.
- `out_valid`  out  4  bit i = lane i holds an undelivered word.
- `out_ready`  in  4  bit i = lane i consumer takes the word this cycle.
- `ptr`  out  2  current round-robin pointer.

## Operation
- Target lane: `t = auto ? ptr : sel`.
- Ready: `in_ready = !reset && (!out_valid[t] || out_ready[t])`. It is combinational from `reset`, `auto`, `sel`, `ptr`, `out_valid` and `out_ready`.
- Accept: an input word is accepted when `in_valid && in_ready`. On accept, `out[t] <= data_in` and `out_valid[t] <= 1`.
- Drain: lane i drains when `out_valid[i] && out_ready[i]`.
  - If lane i is not loaded the same cycle, `out_valid[i] <= 0`.
  - The lane data register keeps its last value after draining; it is not cleared.
- Simultaneous drain and load on the same lane: the new word replaces the old one and `out_valid[t]` stays 1. The old word counts as delivered.
- Lane independence: any subset of lanes may drain in the same cycle. Non-target lanes never block the input.
- Output stability: while `out_valid[i]`=1 and `out_ready[i]`=0, `out[i]` and `out_valid[i]` hold unchanged.
- Round-robin pointer:
  - In `auto`=1, `ptr` increments by 1 on each accept and wraps 3→0.
  - `ptr` holds when there is no accept, or whenever `auto`=0.
  - When `auto` goes 0→1, distribution resumes from the held `ptr` value.
- Input with `in_valid`=0: no state change except lane drains. `data_in` is don't-care.
- Reset (highest priority; also applies mid-operation):
  - Next edge: `out_valid`=0000, `out0`..`out3`=0, `ptr`=00.
  - Buffered words are discarded.
  - `in_ready`=0 for the whole cycle `reset` is high.

## Timing
- Latency: an word accepted at edge N appears on `out[t]` with `out_valid[t]`=1 after edge N.
- Throughput: 1 word/cycle sustained, provided the target lane is empty or draining each cycle.
- `in_ready` has no register stage. A combinational path exists from `out_ready`, `sel`, `auto` and `reset` to `in_ready`.
- All outputs other than `in_ready` are registered.
- First cycle after reset deasserts: all lanes are empty, so `in_ready`=1 for any target.

## Test plan
- Reset: hold `reset` for 2 cycles with `in_valid`=1 → `in_ready`=0 throughout. After release: `out_valid`=0000, `out0`..`out3`=0, `ptr`=00, and `in_ready`=1.
- Manual routing with backpressure: `auto`=0, `sel`=10, `data_in`=0xA, `in_valid`=1, `out_ready`=0000 → next cycle `out2`=0xA and `out_valid`=0100. With `sel`=10, `in_ready`=0; switching to `sel`=01 gives `in_ready`=1.
- Drain and reload same cycle: lane 2 holds 0xA, `sel`=10, `out_ready`=0100, `data_in`=0x5 valid → `in_ready`=1. Next cycle `out2`=0x5 and `out_valid[2]` stays 1.
- Round-robin: `auto`=1, `out_ready`=1111, words 1,2,3,4,5 on consecutive cycles → loads land in lanes 0,1,2,3,0; `ptr` reads 01,10,11,00,01 after each edge. `sel` toggling randomly has no effect.
- Round-robin stall: `auto`=1, `ptr`=01, lane 1 full, `out_ready[1]`=0, lane 0 full with `out_ready[0]`=1 → `in_ready`=0 and `ptr` holds 01. Lane 0 drains (`out_valid[0]`→0) in the same cycle.
- Mid-operation reset: all four lanes full with `out_ready`=0000 and `ptr`=10, then assert `reset` for 1 cycle → next edge `out_valid`=0000, all lanes 0, `ptr`=00, and no words are delivered.
